// File: rtl/video_chunk_request_scheduler.sv
// video_chunk_request_scheduler
//   Walks the active raster of one frame in {line, chunk} order and pushes one
//   request per chunk into the request FIFO of the video generator. The number
//   of chunks in flight is bounded by a credit counter sized to the response
//   FIFO. Credits come back as the scaler pops pixels, one per CHUNK_SIZE pixels.
//
// Ports
//   scalerClock            sole clock, posedge
//   resetN                 asynchronous active-low reset
//   frameStart             pulse; starts a frame when idle
//   lastChunk / lastLine   chunks per line - 1 / lines per frame - 1, latched on start
//   requestFifoWriteEnable push {line, chunk} this cycle
//   requestFifoFull        request FIFO cannot accept a push
//   requestFifoWriteData   {line, chunk} of the next request
//   pixelConsumed          one pixel popped from the response FIFO
//   busy                   a frame is in progress
//   frameDone              pulse: all requests issued and all credits home
//   frameOverrun           pulse: frameStart arrived while busy
//   creditError            sticky: credit returned while credits were full
module video_chunk_request_scheduler #(
    parameter int  CHUNK_BITS      = 5,
    parameter int  MAX_OUTSTANDING = 4,
    localparam int HACTIVE_BITS    = 11,
    localparam int VACTIVE_BITS    = 11,
    localparam int CHUNKNUM_BITS   = HACTIVE_BITS - CHUNK_BITS,
    localparam int REQUEST_BITS    = VACTIVE_BITS + CHUNKNUM_BITS
) (
    input  logic                     scalerClock,
    input  logic                     resetN,
    input  logic                     frameStart,
    input  logic [CHUNKNUM_BITS-1:0] lastChunk,
    input  logic [VACTIVE_BITS-1:0]  lastLine,
    output logic                     requestFifoWriteEnable,
    input  logic                     requestFifoFull,
    output logic [REQUEST_BITS-1:0]  requestFifoWriteData,
    input  logic                     pixelConsumed,
    output logic                     busy,
    output logic                     frameDone,
    output logic                     frameOverrun,
    output logic                     creditError
);

    localparam int CREDIT_BITS = 4;
    localparam logic [CREDIT_BITS-1:0] CREDIT_MAX = CREDIT_BITS'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                   state;
    state_t                   next_state;
    logic [VACTIVE_BITS-1:0]  line_cnt;
    logic [VACTIVE_BITS-1:0]  last_line_q;
    logic [CHUNKNUM_BITS-1:0] chunk_cnt;
    logic [CHUNKNUM_BITS-1:0] last_chunk_q;
    logic [CREDIT_BITS-1:0]   credits;
    logic [CHUNK_BITS-1:0]    pixel_count;
    logic                     issue;
    logic                     chunk_return;
    logic                     frame_done_next;
    logic                     start;

    // Issue and return in the same cycle cancel; a lone return saturates at
    // the full credit count.
    function automatic logic [CREDIT_BITS-1:0] update_credits(
        input logic [CREDIT_BITS-1:0] cur,
        input logic                   take,
        input logic                   give
    );
        logic [CREDIT_BITS-1:0] nxt;
        nxt = cur;
        if (take && !give) begin
            nxt = cur - CREDIT_BITS'(1);
        end else if (give && !take && (cur != CREDIT_MAX)) begin
            nxt = cur + CREDIT_BITS'(1);
        end
        return nxt;
    endfunction

    assign start        = frameStart && (state == IDLE);
    assign chunk_return = pixelConsumed && (pixel_count == {CHUNK_BITS{1'b1}});

    always_comb begin
        next_state      = state;
        issue           = 1'b0;
        frame_done_next = 1'b0;
        case (state)
            IDLE: begin
                if (frameStart) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                issue = (credits != '0) && !requestFifoFull;
                if (issue && (chunk_cnt == last_chunk_q) && (line_cnt == last_line_q)) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (credits == CREDIT_MAX) begin
                    next_state      = IDLE;
                    frame_done_next = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign requestFifoWriteEnable = issue;
    assign requestFifoWriteData   = {line_cnt, chunk_cnt};
    assign busy                   = (state != IDLE);

    always_ff @(posedge scalerClock or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Raster position, latched frame geometry and status pulses
    always_ff @(posedge scalerClock or negedge resetN) begin
        if (!resetN) begin
            line_cnt     <= '0;
            chunk_cnt    <= '0;
            last_line_q  <= '0;
            last_chunk_q <= '0;
            frameDone    <= 1'b0;
            frameOverrun <= 1'b0;
        end else begin
            if (start) begin
                last_line_q  <= lastLine;
                last_chunk_q <= lastChunk;
                line_cnt     <= '0;
                chunk_cnt    <= '0;
            end else if (issue) begin
                if (chunk_cnt == last_chunk_q) begin
                    chunk_cnt <= '0;
                    line_cnt  <= line_cnt + VACTIVE_BITS'(1);
                end else begin
                    chunk_cnt <= chunk_cnt + CHUNKNUM_BITS'(1);
                end
            end
            frameDone    <= frame_done_next;
            frameOverrun <= frameStart && (state != IDLE);
        end
    end

    // Credit accounting; persists across frames
    always_ff @(posedge scalerClock or negedge resetN) begin
        if (!resetN) begin
            credits     <= CREDIT_MAX;
            pixel_count <= '0;
            creditError <= 1'b0;
        end else begin
            if (pixelConsumed) begin
                pixel_count <= pixel_count + CHUNK_BITS'(1);
            end
            credits <= update_credits(credits, issue, chunk_return);
            if (chunk_return && !issue && (credits == CREDIT_MAX)) begin
                creditError <= 1'b1;
            end
        end
    end

endmodule
